regfile: RTL and testbench

- 32-entry x 64-bit integer register file for the core datapath.
- Two asynchronous read ports serve operand fetch; one synchronous write port serves write-back.
- A third read port and a second write port form a debug access path. The debug unit uses it to inspect or patch architectural state.
- Register 31 is the hardwired zero register (XZR).

---
 rtl/regfile.sv | 71 +++++++
 tb/tb_regfile.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// 32 x DATA_W register file: two datapath read ports, one debug read port, datapath and debug write ports.
// Reads are combinational; writes land on the rising edge. Define REGFILE_BYPASS_EN for write-first forwarding.
module regfile #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] ra_db,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [ADDR_W-1:0] wa_db,
  input  logic [DATA_W-1:0] wd3,
  input  logic [DATA_W-1:0] wd_db,
  input  logic              we3,
  input  logic              we_db,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] rd_db
);

  localparam int                DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_wr3;
  logic w_wr_db;

  assign w_wr3   = we3   && (wa3   != ZERO_A);
  assign w_wr_db = we_db && (wa_db != ZERO_A);

  // The debug write is issued last so it overrides the datapath write on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr3) begin
        r_mem[wa3] <= wd3;
      end
      if (w_wr_db) begin
        r_mem[wa_db] <= wd_db;
      end
    end
  end

  function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] v;
    v = r_mem[ra];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_db && (wa_db == ra)) begin
      v = wd_db;
    end else if (w_wr3 && (wa3 == ra)) begin
      v = wd3;
    end
`endif
    if (!rst_n || (ra == ZERO_A)) begin
      v = '0;
    end
    return v;
  endfunction

  assign rd1   = f_read(ra1);
  assign rd2   = f_read(ra2);
  assign rd_db = f_read(ra_db);

endmodule

// File: tb/tb_regfile.sv
// Randomized scoreboard bench for regfile against an array-based architectural model.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ra1, ra2, ra_db, wa3, wa_db;
  logic [63:0] wd3, wd_db;
  logic        we3, we_db;
  logic [63:0] rd1, rd2, rd_db;

  always #5 clk = ~clk;

  regfile dut (
    .clk(clk), .rst_n(rst_n),
    .ra1(ra1), .ra2(ra2), .ra_db(ra_db),
    .wa3(wa3), .wa_db(wa_db), .wd3(wd3), .wd_db(wd_db),
    .we3(we3), .we_db(we_db),
    .rd1(rd1), .rd2(rd2), .rd_db(rd_db)
  );

  typedef struct packed {
    logic [63:0] r1;
    logic [63:0] r2;
    logic [63:0] rdb;
  } exp_t;

  logic [63:0] mdl [32];
  exp_t        expq [$];
  string       tagq [$];
  int          n_chk  = 0;
  int          n_pass = 0;

  // Architectural view: register 31 reads zero, reset reads zero, otherwise the stored value
  // (or, with forwarding, the pending write, debug winning).
  function automatic logic [63:0] ref_rd(input logic [4:0] a);
    if (!rst_n || a == 5'd31) return 64'h0;
`ifdef REGFILE_BYPASS_EN
    if (we_db && wa_db == a) return wd_db;
    if (we3 && wa3 == a) return wd3;
`endif
    return mdl[a];
  endfunction

  task automatic step(input logic r,
                      input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] adb,
                      input logic e3, input logic [4:0] w3a, input logic [63:0] d3,
                      input logic edb, input logic [4:0] wdba, input logic [63:0] ddb,
                      input string tag);
    @(posedge clk);
    if (rst_n) begin
      if (we3 && wa3 != 5'd31) mdl[wa3] = wd3;
      if (we_db && wa_db != 5'd31) mdl[wa_db] = wd_db;
    end
    #1;
    rst_n = r;
    if (!r) for (int i = 0; i < 32; i++) mdl[i] = 64'h0;
    ra1 = a1; ra2 = a2; ra_db = adb;
    we3 = e3; wa3 = w3a; wd3 = d3;
    we_db = edb; wa_db = wdba; wd_db = ddb;
    expq.push_back('{ref_rd(a1), ref_rd(a2), ref_rd(adb)});
    tagq.push_back(tag);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Monitor: compares the response presented in each cycle against the queued expectation.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        t = tagq.pop_front();
        chk({t, "/rd1"},   rd1,   e.r1);
        chk({t, "/rd2"},   rd2,   e.r2);
        chk({t, "/rd_db"}, rd_db, e.rdb);
      end
    end
  end

  function automatic logic [4:0] rnd_a();
    case ($urandom_range(0, 3))
      0:       return 5'd31;
      1:       return 5'($urandom_range(0, 31));
      default: return 5'($urandom_range(0, 7));
    endcase
  endfunction

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 64'h0;
    rst_n = 1'b0;
    ra1 = '0; ra2 = '0; ra_db = '0; wa3 = '0; wa_db = '0;
    wd3 = '0; wd_db = '0; we3 = 1'b0; we_db = 1'b0;

    step(0, 0, 1, 2, 1, 3, ONES, 1, 4, ONES, "reset_init");
    step(0, 3, 4, 30, 0, 0, 0, 0, 0, 0, "reset_hold");

    for (int n = 0; n < 300; n++)
      step(1, rnd_a(), rnd_a(), rnd_a(),
           1'($urandom_range(0, 1)), rnd_a(), {$urandom, $urandom},
           1'($urandom_range(0, 2) == 0), rnd_a(), {$urandom, $urandom}, "rand_a");

    // Mid-run reset while writes are still being presented.
    for (int a = 0; a < 32; a++)
      step(0, 5'(a), 5'(a), 5'(a), 1, 5'(a), ONES, 1, 5'(31 - a), ONES, "reset_sweep");

    step(1, 1, 1, 1, 1, 1, ONES, 0, 0, 0, "wr1_present");
    step(1, 1, 0, 1, 0, 1, 64'h0, 0, 0, 0, "wr1_read");
    step(1, 1, 0, 1, 0, 1, 64'h0, 0, 0, 0, "hold");
    step(1, 31, 1, 31, 1, 31, ONES, 0, 0, 0, "zero_dp_wr");
    step(1, 31, 31, 31, 0, 0, 0, 1, 31, ONES, "zero_db_wr");
    step(1, 31, 31, 31, 0, 0, 0, 0, 0, 0, "zero_read");
    step(1, 5, 5, 5, 1, 5, 64'h1111, 1, 5, 64'h2222, "conflict_wr");
    step(1, 6, 5, 7, 1, 6, 64'h6666, 1, 7, 64'h7777, "conflict_read");
    step(1, 6, 7, 5, 0, 0, 0, 0, 0, 0, "split_read");
    step(1, 3, 3, 3, 1, 3, 64'hABCD, 0, 0, 0, "bypass_pre");
    step(1, 3, 3, 3, 0, 3, 64'h0, 0, 0, 0, "bypass_post");

    for (int n = 0; n < 300; n++)
      step(1, rnd_a(), rnd_a(), rnd_a(),
           1'($urandom_range(0, 1)), rnd_a(), {$urandom, $urandom},
           1'($urandom_range(0, 1)), rnd_a(), {$urandom, $urandom}, "rand_b");

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
    #1;
    if (expq.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, required 0", expq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
